// File: rtl/dcache_write_responder.sv
// Data-cache store responder: accepts a core write request, acks it, forwards it to the
// downstream write port and returns a writeack once the write commits (or times out).
module dcache_write_responder #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TAG_W   = 13,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqcyc,
  input  logic [ADDR_W-1:0] req,
  input  logic [DATA_W-1:0] reqdata,
  input  logic [TAG_W-1:0]  reqtag,
  output logic              reqack,
  output logic              writeack,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [TAG_W-1:0]  mem_wr_tag,
  input  logic              mem_wr_done,
  output logic              busy,
  output logic              misalign_err,
  output logic              timeout_err,
  output logic [31:0]       writes_done
);

  localparam int unsigned CLOG_T = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W  = (CLOG_T > 8) ? CLOG_T : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StAck, StIssue, StWaitDone, StResp} state_e;

  state_e           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  assign accept = reqcyc && reqtag[TAG_W-1];

  // Saturating increment so a huge TIMEOUT can never wrap the counter.
  always_comb begin
    cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= StIdle;
      wait_cnt     <= '0;
      reqack       <= 1'b0;
      writeack     <= 1'b0;
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      mem_wr_tag   <= '0;
      busy         <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      writes_done  <= '0;
    end else begin
      reqack   <= 1'b0;
      writeack <= 1'b0;
      unique case (state)
        StIdle: begin
          if (accept) begin
            mem_wr_addr  <= {req[ADDR_W-1:3], 3'b000};
            mem_wr_data  <= reqdata;
            mem_wr_tag   <= reqtag;
            misalign_err <= misalign_err | (req[2:0] != 3'b000);
            reqack       <= 1'b1;
            busy         <= 1'b1;
            state        <= StAck;
          end
        end
        // reqcyc is still high here and is deliberately not looked at.
        StAck: begin
          mem_wr_valid <= 1'b1;
          state        <= StIssue;
        end
        StIssue: begin
          if (mem_wr_ready) begin
            mem_wr_valid <= 1'b0;
            if (mem_wr_done) begin
              writeack    <= 1'b1;
              writes_done <= writes_done + 32'd1;
              state       <= StResp;
            end else begin
              wait_cnt <= '0;
              state    <= StWaitDone;
            end
          end
        end
        StWaitDone: begin
          if (mem_wr_done) begin
            writeack    <= 1'b1;
            writes_done <= writes_done + 32'd1;
            state       <= StResp;
          end else begin
            wait_cnt <= cnt_inc;
            if ((TIMEOUT != 0) && (cnt_inc >= TIMEOUT_C)) begin
              timeout_err <= 1'b1;
              writeack    <= 1'b1;
              writes_done <= writes_done + 32'd1;
              state       <= StResp;
            end
          end
        end
        StResp: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy         <= 1'b0;
          mem_wr_valid <= 1'b0;
          state        <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_write_responder.sv
// Self-checking bench for dcache_write_responder: scoreboard of expected downstream writes
// plus per-scenario cycle-exact checks.
module tb_dcache_write_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqcyc;
  logic [63:0] req;
  logic [63:0] reqdata;
  logic [12:0] reqtag;
  logic        reqack, writeack, mem_wr_valid, mem_wr_ready, mem_wr_done;
  logic [63:0] mem_wr_addr, mem_wr_data;
  logic [12:0] mem_wr_tag;
  logic        busy, misalign_err, timeout_err;
  logic [31:0] writes_done;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [12:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;
  int   ack_cnt = 0;
  int   reqack_cnt = 0;
  int   exp_acks = 0;
  int   exp_reqacks = 0;
  int   exp_wd = 0;

  dcache_write_responder #(
    .ADDR_W (64),
    .DATA_W (64),
    .TAG_W  (13),
    .TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .reqcyc      (reqcyc),
    .req         (req),
    .reqdata     (reqdata),
    .reqtag      (reqtag),
    .reqack      (reqack),
    .writeack    (writeack),
    .mem_wr_valid(mem_wr_valid),
    .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_tag  (mem_wr_tag),
    .mem_wr_done (mem_wr_done),
    .busy        (busy),
    .misalign_err(misalign_err),
    .timeout_err (timeout_err),
    .writes_done (writes_done)
  );

  always #5 clk = ~clk;

  // Downstream monitor: every accepted handshake must match the oldest expected write.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_wr_valid && mem_wr_ready) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected got addr=%h want no write", mem_wr_addr);
        end else begin
          e = sb.pop_front();
          if (mem_wr_addr !== e.addr || mem_wr_data !== e.data || mem_wr_tag !== e.tag)
            $display("FAIL sb_write got %h/%h/%h want %h/%h/%h", mem_wr_addr, mem_wr_data,
                     mem_wr_tag, e.addr, e.data, e.tag);
          else passes++;
        end
      end
      if (writeack) ack_cnt++;
      if (reqack) reqack_cnt++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d, input logic [12:0] t);
    exp_t x;
    x.addr = a & ~64'h7;
    x.data = d;
    x.tag  = t;
    sb.push_back(x);
  endtask

  // Fast-path write (ready and done together); returns with the DUT back in IDLE.
  task automatic fast_write(input logic [63:0] a, input logic [63:0] d, input logic [12:0] t);
    reqcyc = 1'b1; req = a; reqdata = d; reqtag = t;
    mem_wr_ready = 1'b1; mem_wr_done = 1'b1;
    push(a, d, t);
    cycle();
    cycle();
    reqcyc = 1'b0;
    cycle();
    cycle();
    mem_wr_ready = 1'b0; mem_wr_done = 1'b0;
    exp_acks++; exp_reqacks++; exp_wd++;
  endtask

  task automatic test_reset();
    reset = 1'b1; reqcyc = 1'b0; req = '0; reqdata = '0; reqtag = '0;
    mem_wr_ready = 1'b0; mem_wr_done = 1'b0;
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({reqack, writeack, mem_wr_valid, busy, misalign_err, timeout_err} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000",
               {reqack, writeack, mem_wr_valid, busy, misalign_err, timeout_err});
    else passes++;
    checks++;
    if (writes_done !== 32'd0 || mem_wr_addr !== 64'd0 || mem_wr_tag !== 13'd0)
      $display("FAIL reset_regs got %0d/%h/%h want 0/0/0", writes_done, mem_wr_addr, mem_wr_tag);
    else passes++;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    reqcyc = 1'b1; req = 64'h1000; reqdata = 64'hDEADBEEF; reqtag = 13'h1001;
    mem_wr_ready = 1'b1; mem_wr_done = 1'b1;
    push(req, reqdata, reqtag);
    cycle();
    checks++;
    if (reqack !== 1'b1 || busy !== 1'b1) $display("FAIL single_reqack got %b%b want 11", reqack, busy);
    else passes++;
    cycle();
    reqcyc = 1'b0;
    checks++;
    if (reqack !== 1'b0 || mem_wr_valid !== 1'b1 || mem_wr_addr !== 64'h1000)
      $display("FAIL single_issue got %b%b %h want 01 1000", reqack, mem_wr_valid, mem_wr_addr);
    else passes++;
    cycle();
    exp_acks++; exp_reqacks++; exp_wd++;
    checks++;
    if (writeack !== 1'b1 || writes_done !== 32'd1)
      $display("FAIL single_writeack got %b %0d want 1 1", writeack, writes_done);
    else passes++;
    cycle();
    mem_wr_ready = 1'b0; mem_wr_done = 1'b0;
    checks++;
    if (writeack !== 1'b0 || busy !== 1'b0) $display("FAIL single_idle got %b%b want 00", writeack, busy);
    else passes++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    reqcyc = 1'b1; req = 64'h2008; reqdata = 64'h0123456789ABCDEF; reqtag = 13'h1002;
    mem_wr_ready = 1'b0; mem_wr_done = 1'b0;
    push(req, reqdata, reqtag);
    cycle();
    cycle();
    reqcyc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 64'h2008 || mem_wr_data !== 64'h0123456789ABCDEF
          || reqack !== 1'b0) bad++;
      if (i < 5) cycle();
    end
    checks++;
    if (bad != 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad);
    else passes++;
    mem_wr_ready = 1'b1;
    cycle();
    mem_wr_ready = 1'b0;
    checks++;
    if (mem_wr_valid !== 1'b0 || busy !== 1'b1) $display("FAIL bp_wait got %b%b want 01", mem_wr_valid, busy);
    else passes++;
    cycle();
    cycle();
    checks++;
    if (writeack !== 1'b0) $display("FAIL bp_early_ack got %b want 0", writeack);
    else passes++;
    mem_wr_done = 1'b1;
    cycle();
    mem_wr_done = 1'b0;
    exp_acks++; exp_reqacks++; exp_wd++;
    checks++;
    if (writeack !== 1'b1 || writes_done !== exp_wd)
      $display("FAIL bp_writeack got %b %0d want 1 %0d", writeack, writes_done, exp_wd);
    else passes++;
    cycle();
  endtask

  task automatic test_read_tag();
    int bad = 0;
    reqcyc = 1'b1; req = 64'h5000; reqdata = 64'h77; reqtag = 13'h0FFF;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (reqack !== 1'b0 || mem_wr_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    reqcyc = 1'b0;
    checks++;
    if (bad != 0) $display("FAIL read_tag got %0d active cycles want 0", bad);
    else passes++;
  endtask

  task automatic test_misalign();
    checks++;
    if (misalign_err !== 1'b0) $display("FAIL misalign_pre got %b want 0", misalign_err);
    else passes++;
    reqcyc = 1'b1; req = 64'h1005; reqdata = 64'hCAFE; reqtag = 13'h1003;
    mem_wr_ready = 1'b1; mem_wr_done = 1'b1;
    push(req, reqdata, reqtag);
    cycle();
    checks++;
    if (misalign_err !== 1'b1) $display("FAIL misalign_set got %b want 1", misalign_err);
    else passes++;
    cycle();
    reqcyc = 1'b0;
    checks++;
    if (mem_wr_addr !== 64'h1000) $display("FAIL misalign_addr got %h want 1000", mem_wr_addr);
    else passes++;
    cycle();
    cycle();
    exp_acks++; exp_reqacks++; exp_wd++;
    fast_write(64'h3000, 64'hBEEF, 13'h1004);
    checks++;
    if (misalign_err !== 1'b1 || writes_done !== exp_wd)
      $display("FAIL misalign_sticky got %b %0d want 1 %0d", misalign_err, writes_done, exp_wd);
    else passes++;
  endtask

  task automatic test_timeout();
    int early = 0;
    reqcyc = 1'b1; req = 64'h4000; reqdata = 64'h4444; reqtag = 13'h1005;
    mem_wr_ready = 1'b0; mem_wr_done = 1'b0;
    push(req, reqdata, reqtag);
    cycle();
    cycle();
    reqcyc = 1'b0;
    mem_wr_ready = 1'b1;
    cycle();
    mem_wr_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      if (writeack !== 1'b0 || timeout_err !== 1'b0) early++;
    end
    checks++;
    if (early != 0) $display("FAIL timeout_early got %0d cycles want 0", early);
    else passes++;
    cycle();
    exp_acks++; exp_reqacks++; exp_wd++;
    checks++;
    if (writeack !== 1'b1 || timeout_err !== 1'b1)
      $display("FAIL timeout_fire got %b%b want 11", writeack, timeout_err);
    else passes++;
    cycle();
    fast_write(64'h4100, 64'h41, 13'h1006);
    fast_write(64'h4200, 64'h42, 13'h1007);
    checks++;
    if (writes_done !== exp_wd || timeout_err !== 1'b1)
      $display("FAIL timeout_after got %0d %b want %0d 1", writes_done, timeout_err, exp_wd);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    reqcyc = 1'b1; req = 64'h6000; reqdata = 64'h60; reqtag = 13'h1008;
    mem_wr_ready = 1'b1; mem_wr_done = 1'b1;
    push(req, reqdata, reqtag);
    cycle();
    checks++;
    if (reqack !== 1'b1) $display("FAIL b2b_first got %b want 1", reqack);
    else passes++;
    req = 64'h6100; reqdata = 64'h61; reqtag = 13'h1009;
    push(req, reqdata, reqtag);
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (reqack !== 1'b0) bad++;
    end
    cycle();
    checks++;
    if (bad != 0 || reqack !== 1'b1) $display("FAIL b2b_spacing got %0d/%b want 0/1", bad, reqack);
    else passes++;
    cycle();
    reqcyc = 1'b0;
    cycle();
    cycle();
    mem_wr_ready = 1'b0; mem_wr_done = 1'b0;
    exp_acks += 2; exp_reqacks += 2; exp_wd += 2;
    checks++;
    if (writes_done !== exp_wd) $display("FAIL b2b_count got %0d want %0d", writes_done, exp_wd);
    else passes++;
  endtask

  task automatic test_reset_in_wait();
    reqcyc = 1'b1; req = 64'h7000; reqdata = 64'h70; reqtag = 13'h100A;
    mem_wr_ready = 1'b0; mem_wr_done = 1'b0;
    push(req, reqdata, reqtag);
    cycle();
    cycle();
    reqcyc = 1'b0;
    mem_wr_ready = 1'b1;
    cycle();
    mem_wr_ready = 1'b0;
    cycle();
    exp_reqacks++;
    reset = 1'b0;
    #1;
    exp_wd = 0;
    checks++;
    if ({busy, writeack, mem_wr_valid, misalign_err, timeout_err} !== 5'b0 || writes_done !== 32'd0)
      $display("FAIL rst_wait got %b %0d want 00000 0",
               {busy, writeack, mem_wr_valid, misalign_err, timeout_err}, writes_done);
    else passes++;
    mem_wr_done = 1'b1;
    cycle();
    mem_wr_done = 1'b0;
    checks++;
    if (writeack !== 1'b0 || busy !== 1'b0) $display("FAIL rst_hold got %b%b want 00", writeack, busy);
    else passes++;
    reset = 1'b1;
    cycle();
    fast_write(64'h7100, 64'h71, 13'h100B);
    checks++;
    if (writes_done !== 32'd1) $display("FAIL rst_fresh got %0d want 1", writes_done);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_read_tag();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    cycle();
    checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover got %0d want 0", sb.size());
    else passes++;
    checks++;
    if (ack_cnt != exp_acks) $display("FAIL writeack_total got %0d want %0d", ack_cnt, exp_acks);
    else passes++;
    checks++;
    if (reqack_cnt != exp_reqacks) $display("FAIL reqack_total got %0d want %0d", reqack_cnt, exp_reqacks);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
